// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver: binary-to-BCD (double dabble) or hex split,
// latched into a display register and scanned one digit at a time onto shared segment lines.
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int IN_W     = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   value,
  input  logic              load,
  input  logic              hex,
  input  logic              blank_lz,
  output logic              busy,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int BW   = 4 * DIGITS;
  localparam int PADW = (IN_W > BW) ? IN_W : BW;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW   = $clog2(SCAN_DIV);
  localparam int CW   = (IN_W > 1) ? $clog2(IN_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DEC, S_HEX} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   val_q, val_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     disp_q, disp_d;
  logic              disp_ovf_q, disp_ovf_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [SW-1:0]     pre_q, pre_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic [BW-1:0]     bcd_adj;
  logic [BW:0]       bcd_shift;
  logic [PADW-1:0]   val_pad;
  logic              hex_ovf;
  logic [3:0]        cur_digit;
  logic              upper_nz;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;  4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;  4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;  4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;  4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
    endcase
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                           : bcd_q[4*gi +: 4];
  end
  assign bcd_shift = {bcd_adj, val_q[IN_W-1]};

  // Zero-extend so hex digits past IN_W read as 0; bits past the display flag overflow.
  assign val_pad = PADW'(val_q);
  always_comb begin
    hex_ovf = 1'b0;
    for (int i = BW; i < PADW; i++) hex_ovf = hex_ovf | val_pad[i];
  end

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    disp_d     = disp_q;
    disp_ovf_d = disp_ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          val_d   = value;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CW'(IN_W - 1);
          state_d = hex ? S_HEX : S_DEC;
        end
      end
      S_DEC: begin
        val_d = val_q << 1;
        bcd_d = bcd_shift[BW-1:0];
        ovf_d = ovf_q | bcd_shift[BW];
        cnt_d = cnt_q - CW'(1);
        // The last shift writes the display directly so the update lands on this edge.
        if (cnt_q == '0) begin
          disp_d     = bcd_shift[BW-1:0];
          disp_ovf_d = ovf_q | bcd_shift[BW];
          state_d    = S_IDLE;
        end
      end
      S_HEX: begin
        disp_d     = val_pad[BW-1:0];
        disp_ovf_d = hex_ovf;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pre_d = pre_q + SW'(1);
    idx_d = idx_q;
    if (pre_q == SW'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    cur_digit = '0;
    upper_nz  = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (IW'(j) == idx_q) cur_digit = disp_q[4*j +: 4];
      if ((IW'(j) >= idx_q) && (disp_q[4*j +: 4] != 4'd0)) upper_nz = 1'b1;
    end
    if (disp_ovf_q)
      seg_d = 8'hBF;
    else if (blank_lz && (idx_q != '0) && !upper_nz)
      seg_d = 8'hFF;
    else
      seg_d = glyph(cur_digit);
    an_d = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      val_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
      idx_q      <= '0;
      pre_q      <= '0;
      seg_q      <= 8'hFF;
      an_q       <= '1;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      disp_ovf_q <= disp_ovf_d;
      idx_q      <= idx_d;
      pre_q      <= pre_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed + randomized bench for seg7_scan_driver; expected glyphs come from plain
// decimal/hex arithmetic on the loaded value.
module tb_seg7_scan_driver;
  localparam int DIGITS = 4;
  localparam int IN_W   = 14;
  localparam int IN_W2  = 20;
  localparam int SCAN   = 4;

  logic clk = 1'b0;
  logic rst;
  logic [IN_W-1:0]   value_a;
  logic              load_a, hex_a, blank_a, busy_a;
  logic [7:0]        seg_a;
  logic [DIGITS-1:0] an_a;
  logic [IN_W2-1:0]  value_b;
  logic              load_b, hex_b, blank_b, busy_b;
  logic [7:0]        seg_b;
  logic [DIGITS-1:0] an_b;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(DIGITS), .IN_W(IN_W), .SCAN_DIV(SCAN)) dut_a (
    .clk(clk), .rst(rst), .value(value_a), .load(load_a), .hex(hex_a),
    .blank_lz(blank_a), .busy(busy_a), .seg(seg_a), .an(an_a));

  seg7_scan_driver #(.DIGITS(DIGITS), .IN_W(IN_W2), .SCAN_DIV(SCAN)) dut_b (
    .clk(clk), .rst(rst), .value(value_b), .load(load_b), .hex(hex_b),
    .blank_lz(blank_b), .busy(busy_b), .seg(seg_b), .an(an_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
      12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  // Reference: digit d of v in base 10/16, dash on overflow, FF above the top nonzero digit.
  function automatic logic [7:0] exp_seg(input longint unsigned v, input bit h, input bit bl,
                                         input int d);
    longint unsigned base, p, lim;
    base = h ? 64'd16 : 64'd10;
    p = 1;
    for (int i = 0; i < d; i++) p = p * base;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * base;
    if (v >= lim) return 8'hBF;
    if (bl && d > 0 && v < p) return 8'hFF;
    return glyph(int'((v / p) % base));
  endfunction

  function automatic logic busy_of(input int s);
    return (s != 0) ? busy_b : busy_a;
  endfunction
  function automatic logic [7:0] seg_of(input int s);
    return (s != 0) ? seg_b : seg_a;
  endfunction
  function automatic logic [DIGITS-1:0] an_of(input int s);
    return (s != 0) ? an_b : an_a;
  endfunction
  function automatic int an_digit(input logic [DIGITS-1:0] a);
    for (int i = 0; i < DIGITS; i++) if (a[i] === 1'b0) return i;
    return 0;
  endfunction

  task automatic do_load(input int s, input longint unsigned v, input bit h, input string tag);
    int n;
    if (s == 0) begin value_a = IN_W'(v); hex_a = h; load_a = 1'b1; end
    else        begin value_b = IN_W2'(v); hex_b = h; load_b = 1'b1; end
    tick;
    load_a = 1'b0;
    load_b = 1'b0;
    $display("load %s: dut=%0d value=%0d hex=%0b", tag, s, v, h);
    chk($sformatf("%s_busy_rise", tag), busy_of(s), 1);
    n = 0;
    while (busy_of(s) === 1'b1 && n < 64) begin
      tick;
      n++;
    end
    chk($sformatf("%s_busy_len", tag), n, h ? 1 : ((s != 0) ? IN_W2 : IN_W));
  endtask

  // Align to a digit boundary, then check one full refresh period cycle by cycle.
  task automatic check_scan(input int s, input longint unsigned v, input bit h, input bit bl,
                            input string tag);
    logic [DIGITS-1:0] an0, an_exp;
    int n, d0, d;
    if (s == 0) blank_a = bl; else blank_b = bl;
    an0 = an_of(s);
    n = 0;
    while (an_of(s) === an0 && n < 2 * DIGITS * SCAN) begin
      tick;
      n++;
    end
    chk($sformatf("%s_advance", tag), an_of(s) !== an0, 1);
    d0 = an_digit(an_of(s));
    for (int c = 0; c < DIGITS * SCAN; c++) begin
      d = (d0 + c / SCAN) % DIGITS;
      an_exp = ~(DIGITS'(1) << d);
      chk($sformatf("%s_an", tag), an_of(s), an_exp);
      chk($sformatf("%s_seg_d%0d", tag, d), seg_of(s), exp_seg(v, h, bl, d));
      tick;
    end
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    chk($sformatf("%s_rst_seg", tag), seg_a, 8'hFF);
    chk($sformatf("%s_rst_an", tag), an_a, 4'hF);
    chk($sformatf("%s_rst_busy", tag), busy_a, 0);
    chk($sformatf("%s_rst_busy_b", tag), busy_b, 0);
    tick;
    rst = 1'b0;
    tick;
    chk($sformatf("%s_rel_an", tag), an_a, 4'b1110);
    chk($sformatf("%s_rel_seg", tag), seg_a, 8'hC0);
    $display("reset %s", tag);
  endtask

  initial begin
    int n;
    int s;
    bit h, bl;
    longint unsigned v;

    rst = 1'b1;
    value_a = '0; load_a = 1'b0; hex_a = 1'b0; blank_a = 1'b0;
    value_b = '0; load_b = 1'b0; hex_b = 1'b0; blank_b = 1'b0;
    repeat (3) tick;
    chk("reset_seg", seg_a, 8'hFF);
    chk("reset_an", an_a, 4'hF);
    chk("reset_busy", busy_a, 0);
    rst = 1'b0;
    tick;
    chk("release_an", an_a, 4'b1110);
    chk("release_seg", seg_a, 8'hC0);
    check_scan(0, 0, 0, 0, "zero");

    do_load(0, 1234, 0, "dec1234");
    check_scan(0, 1234, 0, 0, "dec1234");

    // Mid-scan, mid-conversion reset clears the display back to zeros.
    value_a = IN_W'(4321); hex_a = 1'b0; load_a = 1'b1;
    tick;
    load_a = 1'b0;
    repeat (4) tick;
    reset_pulse("midconv");
    check_scan(0, 0, 0, 0, "after_rst");

    do_load(0, 7, 0, "blank7");
    check_scan(0, 7, 0, 1, "blank7");
    n = 0;
    while (an_a !== 4'b1101 && n < 40) begin
      tick;
      n++;
    end
    chk("blank_wait_an", an_a, 4'b1101);
    chk("blank_on_seg", seg_a, 8'hFF);
    blank_a = 1'b0;
    tick;
    chk("blank_off_seg", seg_a, 8'hC0);
    check_scan(0, 7, 0, 0, "noblank7");

    do_load(0, 10000, 0, "dec10000");
    check_scan(0, 10000, 0, 1, "dec10000");
    do_load(0, 9999, 0, "dec9999");
    check_scan(0, 9999, 0, 0, "dec9999");

    do_load(0, 'h3AF, 1, "hex3af");
    check_scan(0, 'h3AF, 1, 1, "hex3af_bl");
    check_scan(0, 'h3AF, 1, 0, "hex3af_nobl");

    do_load(1, 'h10000, 1, "hexovf");
    check_scan(1, 'h10000, 1, 0, "hexovf");
    do_load(1, 'hFFFF, 1, "hexffff");
    check_scan(1, 'hFFFF, 1, 0, "hexffff");
    do_load(1, 123456, 0, "dec_w_ovf");
    check_scan(1, 123456, 0, 0, "dec_w_ovf");

    // Handshake: loads while busy (and on the falling-busy edge) are dropped.
    blank_a = 1'b0;
    value_a = IN_W'(1234); hex_a = 1'b0; load_a = 1'b1;
    tick;                                   // edge k
    load_a = 1'b0;
    chk("hs_busy_k", busy_a, 1);
    repeat (2) tick;
    value_a = IN_W'(5678); load_a = 1'b1;
    tick;                                   // edge k+3
    load_a = 1'b0;
    chk("hs_busy_k3", busy_a, 1);
    repeat (10) tick;
    load_a = 1'b1;
    tick;                                   // edge k+14
    load_a = 1'b0;
    chk("hs_busy_k14", busy_a, 0);
    value_a = IN_W'(4321); load_a = 1'b1;
    tick;                                   // edge k+15
    load_a = 1'b0;
    chk("hs_reload_busy", busy_a, 1);
    for (int c = 0; c < 5; c++) begin
      chk("hs_old_display", seg_a, exp_seg(1234, 0, 0, an_digit(an_a)));
      tick;
    end
    reset_pulse("hs");
    check_scan(0, 0, 0, 0, "hs_cleared");

    for (int i = 0; i < 10; i++) begin
      s  = int'($urandom_range(0, 1));
      h  = 1'($urandom_range(0, 1));
      bl = 1'($urandom_range(0, 1));
      if (s == 0) v = (i % 3 == 0) ? longint'($urandom_range(9990, 10010))
                                   : longint'($urandom_range(0, 16383));
      else        v = longint'($urandom_range(0, (1 << IN_W2) - 1));
      do_load(s, v, h, $sformatf("rnd%0d", i));
      check_scan(s, v, h, bl, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed 7-segment display driver for common-anode displays. It converts a binary value to DIGITS glyphs: decimal via a sequential double-dabble converter, or hexadecimal via direct nibble split. It then time-multiplexes the glyphs onto one shared active-low segment bus with active-low anode enables. It sits between the adder datapath and the board's display pins, and replaces the per-digit combinational decoders.

## Interface
- DIGITS, 4, number of digits scanned; legal range 1..8.
- IN_W, 14, width of `value`; legal range 1..32.
- SCAN_DIV, 50000, clock cycles each digit is lit; legal range 2 and up.

- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- value  in  IN_W  unsigned binary to display; sampled only on an accepted load.
- load  in  1  conversion request; accepted when high at a rising edge with busy=0.
- hex  in  1  mode, sampled with load: 0 = decimal, 1 = hexadecimal.
- blank_lz  in  1  leading-zero blanking enable; live, not sampled with load.
- busy  out  1  high while a conversion is in progress; loads are ignored while high.
- seg  out  8  segments, active-low; bit7 = dp (always 1), bit6 = g … bit0 = a.
- an  out  DIGITS  anode enables, active-low, one-hot-low; bit 0 = least significant (rightmost) digit.

## Operation
- Glyph codes:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - Blank=FF, dash=BF.
- Display register: DIGITS 4-bit codes plus an overflow flag. It changes only at conversion end or reset, atomically. Scanning keeps showing the old contents while busy.
- Decimal mode, double dabble with a 4*DIGITS-bit BCD register:
  - Load clears BCD and captures value.
  - Each cycle, add 3 to every BCD nibble ≥5, then shift in one value bit, MSB first.
  - Exactly IN_W shift cycles.
  - A 1 shifted out of the BCD MSB sets a sticky overflow flag.
- Hex mode:
  - Digit i = value[4i+3:4i]; bits beyond IN_W read as 0.
  - Overflow when any value bit at index ≥4*DIGITS is 1.
- Overflow: every digit shows dash. Blanking does not apply.
- Leading-zero blanking (blank_lz=1): every digit above the most significant nonzero digit shows FF. Digit 0 is never blanked, so value 0 shows "0".
- Scan:
  - The prescaler counts 0..SCAN_DIV-1.
  - At terminal count the digit index advances; DIGITS-1 wraps to 0.
  - With DIGITS=1 the index stays 0.
- Outputs an/seg are registered from the current index and display register. They are glitch-free, and exactly one anode is low at any time after reset.

## Timing
- Reset (async assert): busy=0, seg=FF, an=all ones, display=all zeros, overflow=0, index=0, prescaler=0, converter idle. An in-flight conversion is discarded.
- First rising edge after reset release: an=~1 (digit 0 low), seg=C0.
- Load accepted at edge k:
  - busy=1 after edge k.
  - Decimal: the display register updates and busy falls at edge k+IN_W.
  - Hex: the display register updates and busy falls at edge k+1.
- New value on seg: one edge after the display update, for whichever digit is currently scanned.
- A load high at the edge where busy falls is ignored, because busy was still 1 before that edge. The earliest re-accept is edge k+IN_W+1 (decimal) or k+2 (hex).
- No queuing: loads while busy are dropped, with no error indication.
- Changes to hex or value while busy have no effect. Changes to blank_lz take effect on seg at the next edge.
- Each digit is lit for exactly SCAN_DIV cycles. Full refresh period = DIGITS*SCAN_DIV cycles.

## Test plan
- Reset: assert rst mid-scan and mid-conversion → seg=FF, an=1111, busy=0 immediately. One edge after release, an=1110, seg=C0.
- Decimal, defaults with SCAN_DIV=4: load value=1234 → busy high for exactly 14 cycles. Scanning digits 0..3 then gives seg=99, B0, A4, F9, each for 4 cycles, an cycling 1110→1101→1011→0111→1110.
- Blanking: load value=7 with blank_lz=1 → digits 1..3 seg=FF, digit 0 seg=F8. Drop blank_lz → digits 1..3 seg=C0 from the next edge.
- Overflow:
  - Decimal: load 10000 → all four digits seg=BF.
  - Decimal: load 9999 → all 90.
  - Hex with IN_W=20: load 0x10000 → all BF.
- Hex: load 0x3AF with hex=1 → busy high exactly one cycle. Digits 0..2 show 8E, 88, B0; digit 3 shows FF with blank_lz=1, C0 with blank_lz=0.
- Handshake: load 1234, then pulse load=1 with 5678 at edges k+3 and k+14 → both dropped and 1234 is displayed. Reload at edge k+15 is accepted. Asserting rst during that conversion leaves the display at 0000.
